// File: rtl/reg_scratch_responder.sv
`default_nettype none
// ============================================================================
// Module   : reg_scratch_responder
// Purpose  : Register-bus responder for the peripheral CSR window. Holds
//            NUM_REGS scratch registers, a sticky write-lock and a counter
//            of successful writes. Every response is delayed by WAIT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scratch_responder #(
    parameter int NUM_REGS    = 8,
    parameter int ADDR_WIDTH  = 48,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [31:0]             req_wdata_i,
    input  logic [3:0]              req_wstrb_i,
    output logic                    rsp_ready_o,
    output logic [31:0]             rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic [32*NUM_REGS-1:0]  scratch_o,
    output logic                    lock_o
);

    localparam int         c_IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [9:0] c_NREGS    = 10'(NUM_REGS);
    localparam logic [11:0] c_OFF_LOCK = 12'h080;
    localparam logic [11:0] c_OFF_CNT  = 12'h084;
    localparam logic [3:0] c_CNT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_nxt;
    logic                 w_fire;
    logic                 w_resp;
    logic                 w_commit;

    logic [31:0]          r_scratch [NUM_REGS];
    logic                 r_lock;
    logic [31:0]          r_access_cnt;

    logic [11:0]          w_off;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_hit_scr;
    logic                 w_hit_lock;
    logic                 w_hit_cnt;
    logic                 w_err;
    logic [31:0]          w_rdval;
    logic                 w_unused_addr;

    // The upstream demux has already selected this block; high bits are don't-care.
    assign w_unused_addr = ^req_addr_i[ADDR_WIDTH-1:12];

    // Address decode on the 4 KiB window offset.
    assign w_off      = req_addr_i[11:0];
    assign w_idx      = w_off[c_IDX_W+1:2];
    assign w_hit_scr  = (w_off[1:0] == 2'b00) && (w_off[11:2] < c_NREGS);
    assign w_hit_lock = (w_off == c_OFF_LOCK);
    assign w_hit_cnt  = (w_off == c_OFF_CNT);
    assign w_err      = !(w_hit_scr || w_hit_lock || w_hit_cnt)
                      || (req_write_i && w_hit_cnt)
                      || (req_write_i && w_hit_scr && r_lock);

    // Read mux over pre-commit register state.
    always_comb begin
        w_rdval = 32'h0;
        if (w_hit_scr) begin
            w_rdval = r_scratch[w_idx];
        end else if (w_hit_lock) begin
            w_rdval = {31'b0, r_lock};
        end else if (w_hit_cnt) begin
            w_rdval = r_access_cnt;
        end
    end

    // Byte-strobe merge of write data into an existing word.
    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // FSM state and wait counter; reset aborts any pending transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; w_fire marks the response/commit cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (WAIT_CYCLES == 0) begin
                        w_fire = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!req_valid_i) begin
                    // Requester withdrew: drop silently, nothing committed.
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_fire      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Response outputs are forced quiet while reset is asserted.
    assign w_resp      = w_fire & ~rst_i;
    assign w_commit    = w_resp & req_write_i & ~w_err;
    assign rsp_ready_o = w_resp;
    assign rsp_error_o = w_resp & w_err;
    assign rsp_rdata_o = (w_resp && !w_err && !req_write_i) ? w_rdval : 32'h0;

    // Register file update on the committing edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_scratch[i] <= 32'h0;
            end
            r_lock       <= 1'b0;
            r_access_cnt <= 32'h0;
        end else if (w_commit) begin
            if (w_hit_scr) begin
                r_scratch[w_idx] <= f_merge(r_scratch[w_idx], req_wdata_i, req_wstrb_i);
            end
            if (w_hit_lock && req_wstrb_i[0] && req_wdata_i[0]) begin
                r_lock <= 1'b1;
            end
            r_access_cnt <= r_access_cnt + 32'd1;
        end
    end

    // Flatten scratch contents for the SoC configuration bus.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign scratch_o[32*g +: 32] = r_scratch[g];
    end

    assign lock_o = r_lock;

    // Requester must hold the request steady until the response.
    a_req_stable: assert property (@(posedge clk_i)
        (!rst_i && req_valid_i && !rsp_ready_o) |=>
        (rst_i || (req_valid_i &&
                   $stable({req_write_i, req_addr_i, req_wdata_i, req_wstrb_i}))));

    if (WAIT_CYCLES > 0) begin : g_sva_wait
        // With wait states there is always an idle cycle between responses.
        a_no_b2b: assert property (@(posedge clk_i) rsp_ready_o |=> !rsp_ready_o);
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_scratch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scratch_responder
// Purpose  : Self-checking bench for reg_scratch_responder. Four instances
//            with different wait-state settings are checked against a
//            behavioural register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scratch_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         t_v    [4];
    logic         t_wr   [4];
    logic [47:0]  t_addr [4];
    logic [31:0]  t_wd   [4];
    logic [3:0]   t_ws   [4];
    logic         rdy    [4];
    logic [31:0]  rdata  [4];
    logic         errs   [4];
    logic [255:0] scr    [4];
    logic         lk     [4];

    reg_scratch_responder #(.NUM_REGS(8), .ADDR_WIDTH(48), .WAIT_CYCLES(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(t_v[0]), .req_write_i(t_wr[0]),
        .req_addr_i(t_addr[0]), .req_wdata_i(t_wd[0]), .req_wstrb_i(t_ws[0]),
        .rsp_ready_o(rdy[0]), .rsp_rdata_o(rdata[0]), .rsp_error_o(errs[0]),
        .scratch_o(scr[0]), .lock_o(lk[0]));
    reg_scratch_responder #(.NUM_REGS(8), .ADDR_WIDTH(48), .WAIT_CYCLES(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(t_v[1]), .req_write_i(t_wr[1]),
        .req_addr_i(t_addr[1]), .req_wdata_i(t_wd[1]), .req_wstrb_i(t_ws[1]),
        .rsp_ready_o(rdy[1]), .rsp_rdata_o(rdata[1]), .rsp_error_o(errs[1]),
        .scratch_o(scr[1]), .lock_o(lk[1]));
    reg_scratch_responder #(.NUM_REGS(8), .ADDR_WIDTH(48), .WAIT_CYCLES(4)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(t_v[2]), .req_write_i(t_wr[2]),
        .req_addr_i(t_addr[2]), .req_wdata_i(t_wd[2]), .req_wstrb_i(t_ws[2]),
        .rsp_ready_o(rdy[2]), .rsp_rdata_o(rdata[2]), .rsp_error_o(errs[2]),
        .scratch_o(scr[2]), .lock_o(lk[2]));
    reg_scratch_responder #(.NUM_REGS(8), .ADDR_WIDTH(48), .WAIT_CYCLES(15)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(t_v[3]), .req_write_i(t_wr[3]),
        .req_addr_i(t_addr[3]), .req_wdata_i(t_wd[3]), .req_wstrb_i(t_ws[3]),
        .rsp_ready_o(rdy[3]), .rsp_rdata_o(rdata[3]), .rsp_error_o(errs[3]),
        .scratch_o(scr[3]), .lock_o(lk[3]));

    // Behavioural register map, one copy per instance.
    logic [31:0] m_scr  [4][8];
    logic        m_lock [4];
    logic [31:0] m_cnt  [4];

    int n_checks = 0;
    int n_err    = 0;

    function automatic int wc_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            2:       return 4;
            default: return 15;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) m_scr[k][i] = 32'h0;
            m_lock[k] = 1'b0;
            m_cnt[k]  = 32'h0;
        end
    endtask

    function automatic logic [255:0] m_pack(input int k);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[32*i +: 32] = m_scr[k][i];
        return p;
    endfunction

    // Register-map rules: scratch words, LOCK at 0x80, counter at 0x84.
    task automatic model_access(input int k, input logic w, input logic [11:0] off,
                                input logic [31:0] wd, input logic [3:0] ws,
                                output logic [31:0] rd, output logic er);
        int  idx;
        bit  is_scr, is_lock, is_cnt;
        idx     = int'(off) / 4;
        is_scr  = (int'(off) % 4 == 0) && (idx < 8);
        is_lock = (off == 12'h080);
        is_cnt  = (off == 12'h084);
        er = !(is_scr || is_lock || is_cnt) || (w && is_cnt) || (w && is_scr && m_lock[k]);
        rd = 32'h0;
        if (!er && !w) begin
            if (is_scr)       rd = m_scr[k][idx];
            else if (is_lock) rd = {31'b0, m_lock[k]};
            else              rd = m_cnt[k];
        end
        if (!er && w) begin
            if (is_scr) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) m_scr[k][idx][8*b +: 8] = wd[8*b +: 8];
            end
            if (is_lock && ws[0] && wd[0]) m_lock[k] = 1'b1;
            m_cnt[k] = m_cnt[k] + 32'd1;
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete bus transaction on instance k, checked against the model.
    task automatic access(input int k, input logic w, input logic [11:0] off,
                          input logic [31:0] wd, input logic [3:0] ws, input string tag,
                          output logic [31:0] o_rd, output logic o_err);
        logic [63:0] rr;
        logic [31:0] e_rd;
        logic        e_err;
        int          lat;
        rr = {$urandom, $urandom};
        @(negedge clk);
        t_wr[k] = w; t_addr[k] = {rr[47:12], off}; t_wd[k] = wd; t_ws[k] = ws;
        t_v[k] = 1'b1;
        #1;
        lat = 0;
        while (rdy[k] !== 1'b1 && lat < 40) begin
            @(negedge clk); #1;
            lat++;
        end
        o_rd  = rdata[k];
        o_err = errs[k];
        model_access(k, w, off, wd, ws, e_rd, e_err);
        chk({tag, "/latency"}, 256'(lat), 256'(wc_of(k)));
        chk({tag, "/error"}, 256'(o_err), 256'(e_err));
        if (!w) chk({tag, "/rdata"}, 256'(o_rd), 256'(e_rd));
        @(posedge clk); #1;
        t_v[k] = 1'b0;
        chk({tag, "/scratch_o"}, scr[k], m_pack(k));
        chk({tag, "/lock_o"}, 256'(lk[k]), 256'(m_lock[k]));
    endtask

    // Hold a counter read valid for three response periods.
    task automatic stream(input int k);
        int w, m, bad, pulses;
        w = wc_of(k); m = 3 * (w + 1); bad = 0; pulses = 0;
        @(negedge clk);
        t_wr[k] = 1'b0; t_addr[k] = {36'h0, 12'h084}; t_v[k] = 1'b1;
        #1;
        for (int j = 0; j < m; j++) begin
            if (j > 0) begin @(negedge clk); #1; end
            if (rdy[k] !== ((j % (w + 1)) == w)) bad++;
            if (rdy[k] === 1'b1) begin
                pulses++;
                if (rdata[k] !== m_cnt[k]) bad++;
            end
        end
        @(posedge clk); #1;
        t_v[k] = 1'b0;
        chk($sformatf("stream%0d/bad_cycles", k), 256'(bad), 256'(0));
        chk($sformatf("stream%0d/pulses", k), 256'(pulses), 256'(3));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d_rd;
        logic        d_err;
        logic        seen;
        logic [11:0] off;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        w;
        int          cat, n;

        for (int k = 0; k < 4; k++) begin
            t_v[k] = 1'b0; t_wr[k] = 1'b0; t_addr[k] = '0; t_wd[k] = '0; t_ws[k] = '0;
        end
        model_reset();

        // Reset state, including a request presented during reset.
        repeat (2) @(negedge clk);
        t_v[1] = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset%0d/ready", k), 256'(rdy[k]), 256'(0));
            chk($sformatf("reset%0d/rdata", k), 256'(rdata[k]), 256'(0));
            chk($sformatf("reset%0d/error", k), 256'(errs[k]), 256'(0));
            chk($sformatf("reset%0d/scratch", k), scr[k], 256'(0));
            chk($sformatf("reset%0d/lock", k), 256'(lk[k]), 256'(0));
        end
        t_v[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Default read.
        access(0, 1'b0, 12'h004, 32'h0, 4'h0, "rd_default", d_rd, d_err);
        chk("rd_default/value", 256'(d_rd), 256'(0));

        // Strobed writes.
        access(0, 1'b1, 12'h000, 32'hDEADBEEF, 4'hF, "wr_full", d_rd, d_err);
        access(0, 1'b1, 12'h000, 32'h11223344, 4'h5, "wr_strb", d_rd, d_err);
        access(0, 1'b0, 12'h000, 32'h0, 4'h0, "rd_merge", d_rd, d_err);
        chk("rd_merge/value", 256'(d_rd), 256'(32'hDE22BE44));
        access(0, 1'b0, 12'h084, 32'h0, 4'h0, "rd_cnt2", d_rd, d_err);
        chk("rd_cnt2/value", 256'(d_rd), 256'(2));

        // Lock behaviour.
        access(0, 1'b1, 12'h080, 32'h1, 4'hF, "lock_set", d_rd, d_err);
        chk("lock_set/lock_o", 256'(lk[0]), 256'(1));
        access(0, 1'b1, 12'h008, 32'hA5A5A5A5, 4'hF, "wr_locked", d_rd, d_err);
        chk("wr_locked/err", 256'(d_err), 256'(1));
        chk("wr_locked/scratch2", 256'(scr[0][95:64]), 256'(0));
        access(0, 1'b1, 12'h080, 32'h0, 4'hF, "lock_wr0", d_rd, d_err);
        chk("lock_wr0/lock_o", 256'(lk[0]), 256'(1));

        // Error cases.
        access(0, 1'b0, 12'h002, 32'h0, 4'h0, "rd_unaligned", d_rd, d_err);
        chk("rd_unaligned/err", 256'(d_err), 256'(1));
        access(0, 1'b0, 12'h040, 32'h0, 4'h0, "rd_unmapped", d_rd, d_err);
        chk("rd_unmapped/err", 256'(d_err), 256'(1));
        access(0, 1'b1, 12'h084, 32'h12345678, 4'hF, "wr_cnt", d_rd, d_err);
        chk("wr_cnt/err", 256'(d_err), 256'(1));
        access(0, 1'b0, 12'h084, 32'h0, 4'h0, "rd_cnt_after", d_rd, d_err);

        // Reset clears the sticky lock.
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_lock/lock_o", 256'(lk[0]), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // Latency sweep and continuous-valid throughput on every instance.
        for (int k = 0; k < 4; k++) begin
            access(k, 1'b0, 12'h010, 32'h0, 4'h0, $sformatf("latency%0d", k), d_rd, d_err);
            stream(k);
        end

        // Reset during the wait phase of a write aborts it.
        @(negedge clk);
        t_wr[2] = 1'b1; t_addr[2] = {36'h0, 12'h00C}; t_wd[2] = 32'hCAFEF00D;
        t_ws[2] = 4'hF; t_v[2] = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 2; j++) begin
            #1;
            if (rdy[2] === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        if (rdy[2] === 1'b1) seen = 1'b1;
        @(negedge clk);
        t_v[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); #1;
            if (rdy[2] === 1'b1) seen = 1'b1;
        end
        chk("abort/no_ready", 256'(seen), 256'(0));
        chk("abort/scratch3", 256'(scr[2][127:96]), 256'(0));
        access(2, 1'b0, 12'h00C, 32'h0, 4'h0, "abort/readback", d_rd, d_err);
        access(2, 1'b0, 12'h084, 32'h0, 4'h0, "abort/cnt", d_rd, d_err);

        // Counter wrap.
        @(negedge clk);
        force u_dut0.r_access_cnt = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release u_dut0.r_access_cnt;
        m_cnt[0] = 32'hFFFF_FFFF;
        access(0, 1'b0, 12'h084, 32'h0, 4'h0, "wrap/pre", d_rd, d_err);
        access(0, 1'b1, 12'h01C, 32'h5A5A0F0F, 4'hF, "wrap/write", d_rd, d_err);
        access(0, 1'b0, 12'h084, 32'h0, 4'h0, "wrap/post", d_rd, d_err);
        chk("wrap/value", 256'(d_rd), 256'(0));

        // Randomized traffic on every instance.
        for (int k = 0; k < 4; k++) begin
            n = (k == 3) ? 8 : 30;
            for (int i = 0; i < n; i++) begin
                cat = $urandom_range(0, 5);
                case (cat)
                    0, 1:    off = 12'(4 * $urandom_range(0, 7));
                    2:       off = 12'h080;
                    3:       off = 12'h084;
                    4:       off = 12'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
                    default: off = 12'(12'h088 + 4 * $urandom_range(0, 990));
                endcase
                w  = 1'($urandom_range(0, 1));
                wd = $urandom;
                ws = 4'($urandom);
                if (cat == 2 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
                access(k, w, off, wd, ws, $sformatf("random%0d", k), d_rd, d_err);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_scratch_responder.md
Name: reg_scratch_responder

Overview:
- Register-bus responder that serves the CSR window of the peripheral regbus demux (base 0x0200_4000, 4 KiB).
- Provides NumRegs 32-bit scratch registers, a sticky write-lock register and a write-access counter.
- Applies a configurable wait-state latency before each response.
- Scratch contents are exported to the SoC as boot/mode configuration.

Parameters:
- NumRegs, 8, number of 32-bit scratch registers (1..32), at offsets 0x000..4*NumRegs-4.
- AddrWidth, 48, regbus address width; only addr[11:0] are decoded.
- WaitCycles, 1, cycles between request acceptance and response (0..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  regbus request valid.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  AddrWidth  byte address.
- req_wdata_i  in  32  write data.
- req_wstrb_i  in  4  byte-enable strobes.
- rsp_ready_o  out  1  response valid / request consumed, one-cycle pulse.
- rsp_rdata_o  out  32  read data, valid while rsp_ready_o is high.
- rsp_error_o  out  1  access error, valid while rsp_ready_o is high.
- scratch_o  out  32*NumRegs  current scratch contents; reg i is at bits [32i+31:32i].
- lock_o  out  1  lock status.

Behaviour:
- Reset values while rst_i is high: all scratch registers 0; lock 0; ACCESS_CNT 0; FSM in IDLE; rsp_ready_o 0; rsp_rdata_o 0; rsp_error_o 0.
- Reset mid-transaction aborts the transaction: no register update and no response.
- Register map, using off = addr[11:0]:
  - 0x000..4*NumRegs-4: SCRATCH[off>>2], read/write.
  - 0x080: LOCK, bit0 only; write 1 sets it; writing 0 has no effect; it clears only on reset; reads return {31'b0, lock}.
  - 0x084: ACCESS_CNT, read-only; increments on each successful write; wraps 0xFFFF_FFFF -> 0.
- rsp_error_o = 1 if any of the following holds:
  - off[1:0] != 0;
  - the offset is unmapped;
  - a write targets ACCESS_CNT;
  - a write targets SCRATCH while lock = 1.
- An errored access modifies no state and returns rdata 0. Writes to LOCK are always permitted.
- Writes:
  - Per-byte strobe merge; byte b is updated iff wstrb[b].
  - wstrb = 0 on a legal write is a successful no-op, but still increments ACCESS_CNT.
  - A LOCK write with wstrb[0] = 0 has no effect.
- Reads: rdata reflects register state before any same-cycle commit.
- Address bits above [11:0] are ignored; the upstream demux has already selected this block.
- FSM, WaitCycles > 0:
  - IDLE: on req_valid_i, load cnt = WaitCycles-1 and go to WAIT.
  - WAIT: if cnt != 0, decrement. If cnt == 0, assert rsp_ready_o, commit the write / drive rdata, and return to IDLE.
  - Latency: valid in cycle t gives ready in cycle t+WaitCycles.
- FSM, WaitCycles = 0: rsp_ready_o = req_valid_i combinationally in IDLE; commit happens on the same clock edge; the WAIT state is unused.
- The request must be held stable until ready.
- If req_valid_i drops during WAIT, the FSM returns to IDLE with no commit and no response. This is a protocol violation, covered by an assertion in simulation only.
- After a response cycle the FSM is in IDLE. A still-high req_valid_i is treated as a new request; there is no back-to-back acceptance in the response cycle. Throughput is 1 per WaitCycles+1 cycles (WaitCycles > 0).
- scratch_o and lock_o update on the clock edge of the committing cycle (registered outputs).
- Assertions:
  - rsp_ready_o is never high for two consecutive cycles when WaitCycles > 0.
  - Request fields are stable while valid is high and ready is low.

Test Plan:
- Reset and default read (WaitCycles = 1): after reset, read 0x004 -> ready at t+1, rdata 0x0, error 0; scratch_o all 0; lock_o 0.
- Strobed write: write 0x000 data 0xDEADBEEF wstrb 0xF, then data 0x11223344 wstrb 0x5 -> read returns 0xDE22BE44; ACCESS_CNT reads 2.
- Lock: write 0x080 data 0x1; write 0x008 data 0xA5A5A5A5 -> error 1, SCRATCH[2] stays 0; write 0x080 data 0x0 -> lock_o stays 1; reset -> lock_o 0.
- Errors:
  - read 0x002 -> error 1, rdata 0;
  - read 0x040 (NumRegs = 8) -> error 1;
  - write 0x084 -> error 1, counter unchanged.
- Latency sweep: WaitCycles in {0, 1, 4, 15} -> ready exactly WaitCycles cycles after valid (combinational when 0); continuous valid yields one response every WaitCycles+1 cycles.
- Abort and wrap:
  - Assert rst_i during WAIT of a write to 0x00C -> no update, no ready pulse.
  - Force ACCESS_CNT to 0xFFFFFFFF, then do one legal write -> reads 0x0.
